// File: rtl/systolic_pkg.sv
// Purpose: shared widths and the weight-source FSM state type for the systolic datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package systolic_pkg;

    localparam int DATA_W = 64;
    localparam int DIM_W  = 16;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } wsrc_state_t;

endpackage

// File: rtl/wsrc_fifo2.sv
// Purpose: 2-entry beat FIFO (payload + last) with occupancy count; head shows the arriving word when empty.
// Latency: 0 cycles when empty (write-through), otherwise head register.
// Backpressure: rd_vld independent of rd_rdy; producer must keep count plus pending writes <= 2.
module wsrc_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         wr_last,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         rd_last,
    output logic [1:0]   count
);

    logic [W-1:0] s0_dat_q, s0_dat_d, s1_dat_q, s1_dat_d;
    logic         s0_last_q, s0_last_d, s1_last_q, s1_last_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    // Empty FIFO presents the incoming word directly so a read can be consumed the cycle it lands.
    assign rd_vld  = (count_q != 2'd0) || wr_vld;
    assign rd_dat  = (count_q != 2'd0) ? s0_dat_q  : (wr_vld ? wr_dat  : '0);
    assign rd_last = (count_q != 2'd0) ? s0_last_q : (wr_vld && wr_last);
    assign count   = count_q;
    assign pop     = rd_vld && rd_rdy;

    // Slot update: s0 is always the head, s1 the second entry.
    always_comb begin
        s0_dat_d  = s0_dat_q;
        s0_last_d = s0_last_q;
        s1_dat_d  = s1_dat_q;
        s1_last_d = s1_last_q;
        count_d   = count_q;
        case (count_q)
            2'd0: begin
                if (wr_vld && !rd_rdy) begin
                    s0_dat_d  = wr_dat;
                    s0_last_d = wr_last;
                    count_d   = 2'd1;
                end
            end
            2'd1: begin
                if (pop && wr_vld) begin
                    s0_dat_d  = wr_dat;
                    s0_last_d = wr_last;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (wr_vld) begin
                    s1_dat_d  = wr_dat;
                    s1_last_d = wr_last;
                    count_d   = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    s0_dat_d  = s1_dat_q;
                    s0_last_d = s1_last_q;
                    if (wr_vld) begin
                        s1_dat_d  = wr_dat;
                        s1_last_d = wr_last;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    // Storage registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_dat_q  <= '0;
            s0_last_q <= 1'b0;
            s1_dat_q  <= '0;
            s1_last_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            s0_dat_q  <= s0_dat_d;
            s0_last_q <= s0_last_d;
            s1_dat_q  <= s1_dat_d;
            s1_last_q <= s1_last_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/weight_stream_source.sv
// Purpose: streams Matrix_Row*Matrix_Col/8 packed int8 weight beats from sync-read memory; optional checksum via WEIGHT_SRC_CHECKSUM_EN.
// Latency: start at cycle 0 -> first read cycle 2 -> first m_valid cycle 3; one beat/cycle sustained.
// Backpressure: valid/ready; reads stop once buffered plus in-flight words reach 2.
module weight_stream_source #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int ADDR_W = 20,
    parameter int DIM_W  = systolic_pkg::DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  Matrix_Row,
    input  logic [DIM_W-1:0]  Matrix_Col,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_payload,
    output logic              m_last,
    output logic              busy,
    output logic              done
`ifdef WEIGHT_SRC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    import systolic_pkg::*;

    wsrc_state_t       state_q, state_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       total_q, total_d, rd_cnt_q, rd_cnt_d;
    logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic [31:0]       calc_total;
    logic [1:0]        fifo_count, occupancy;
    logic              fifo_vld, fifo_last, issue, hs_last;
    logic [DATA_W-1:0] fifo_dat;

    wsrc_fifo2 #(.W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_vld  (inflight_q),
        .wr_dat  (mem_rdata),
        .wr_last (inflight_last_q),
        .rd_rdy  (m_ready),
        .rd_vld  (fifo_vld),
        .rd_dat  (fifo_dat),
        .rd_last (fifo_last),
        .count   (fifo_count)
    );

    // Low three column bits drop out: each beat carries eight columns.
    assign calc_total = 32'(row_q) * 32'(col_q >> 3);
    assign occupancy  = fifo_count + {1'b0, inflight_q};
    assign issue      = (state_q == RUN) && (occupancy < 2'd2);
    assign hs_last    = fifo_vld && m_ready && fifo_last;

    assign mem_ren   = issue;
    assign mem_raddr = issue ? (base_q + rd_cnt_q[ADDR_W-1:0]) : '0;
    assign m_valid   = fifo_vld;
    assign m_payload = fifo_dat;
    assign m_last    = fifo_last;
    assign busy      = (state_q == CALC) || (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    // Next-state and counter logic; RUN leaves on the issue that makes rd_cnt reach total.
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        base_d          = base_q;
        total_d         = total_q;
        rd_cnt_d        = rd_cnt_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rd_cnt_q == total_q - 32'd1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d    = Matrix_Row;
                    col_d    = Matrix_Col;
                    base_d   = base_addr;
                    rd_cnt_d = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                total_d = calc_total;
                state_d = (calc_total != 32'd0) ? RUN : DONE;
            end
            RUN: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                    if (rd_cnt_q + 32'd1 == total_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset also drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            base_q          <= '0;
            total_q         <= '0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            base_q          <= base_d;
            total_q         <= total_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

`ifdef WEIGHT_SRC_CHECKSUM_EN
    localparam int NLANES = DATA_W / 8;
    logic [31:0] cksum_q, cksum_d, lane_sum;

    // Sign-extended lane sum of the handshaken beat, accumulated with wraparound.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_sum = lane_sum + {{24{fifo_dat[8*i+7]}}, fifo_dat[8*i +: 8]};
        end
        cksum_d = cksum_q;
        if (state_q == IDLE && start) begin
            cksum_d = '0;
        end else if (fifo_vld && m_ready) begin
            cksum_d = cksum_q + lane_sum;
        end
    end

    // Checksum accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign checksum = cksum_q;
`endif

endmodule

// File: tb/tb_weight_stream_source.sv
// Scoreboard bench for weight_stream_source: expected reads and beats are queued at start,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_weight_stream_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] Matrix_Row, Matrix_Col;
    logic [19:0] base_addr;
    logic        mem_ren;
    logic [19:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic        m_valid, m_ready, m_last, busy, done;
    logic [63:0] m_payload;
`ifdef WEIGHT_SRC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    weight_stream_source dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Matrix_Row (Matrix_Row),
        .Matrix_Col (Matrix_Col),
        .base_addr  (base_addr),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_payload  (m_payload),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
`ifdef WEIGHT_SRC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mem_mode = 0;
    int rdy_mode = 0;
    int first_vld, done_cyc, last_hs;
    bit saw_ren, saw_vld;
    int n_rd = 0, n_hs = 0;
    bit prev_stall = 0;
    logic [63:0] prev_pay;
    logic        prev_last;
    logic [19:0] exp_addr[$];
    logic [64:0] exp_beat[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [19:0] a);
        case (mem_mode)
            0:       return {44'd0, a};
            1:       return {64{1'b1}};
            default: return {12'hA5C, a, 12'h3C5, a ^ 20'hF0F0F};
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: data one cycle after the read enable.
    always @(posedge clk) if (mem_ren) mem_rdata <= mem_word(mem_raddr);

    // Ready driver: 0 = always ready, 1 = 3 on / 5 off, 2 = random.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc - start_cyc) % 8) < 3;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares reads and beats against the queued expectations.
    always @(negedge clk) begin
        if (reset) begin
            n_rd = 0;
            n_hs = 0;
            prev_stall = 0;
        end else begin
            if (mem_ren || m_valid)
                chk("occupancy_le_2", 64'((n_rd - n_hs) <= 2), 64'd1);
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_payload", m_payload, prev_pay);
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (mem_ren) begin
                saw_ren = 1;
                n_rd++;
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", mem_raddr);
                end else begin
                    chk("read_addr", 64'(mem_raddr), 64'(exp_addr.pop_front()));
                end
            end
            if (m_valid) begin
                saw_vld = 1;
                if (first_vld < 0) first_vld = cyc - start_cyc;
            end
            if (m_valid && m_ready) begin
                n_hs++;
                if (exp_beat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_payload);
                end else begin
                    logic [64:0] e;
                    e = exp_beat.pop_front();
                    chk("beat_payload", m_payload, e[63:0]);
                    chk("beat_last", 64'(m_last), 64'(e[64]));
                end
                if (m_last) last_hs = cyc - start_cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_pay   = m_payload;
            prev_last  = m_last;
            if (done) begin
                done_cyc = cyc - start_cyc;
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Reference model: beat k carries memory word (base + k) mod 2^20, last on k == total-1.
    task automatic push_exp(input int row, input int col, input logic [19:0] base, output int total);
        total = row * (col / 8);
        for (int k = 0; k < total; k++) begin
            logic [19:0] a;
            a = base + 20'(k);
            exp_addr.push_back(a);
            exp_beat.push_back({(k == total - 1), mem_word(a)});
        end
    endtask

    task automatic do_start(input int row, input int col, input logic [19:0] base);
        @(posedge clk);
        #1;
        Matrix_Row = 16'(row);
        Matrix_Col = 16'(col);
        base_addr  = base;
        start      = 1'b1;
        start_cyc  = cyc;
        first_vld  = -1;
        done_cyc   = -1;
        last_hs    = -1;
        saw_ren    = 0;
        saw_vld    = 0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        Matrix_Row = 16'($urandom);
        Matrix_Col = 16'($urandom);
        base_addr  = 20'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_block(input int row, input int col, input logic [19:0] base,
                             input int rmode, input bit inject_start);
        int total;
        int budget;
        rdy_mode = rmode;
        push_exp(row, col, base, total);
        do_start(row, col, base);
        if (inject_start) begin
            repeat (8) @(posedge clk);
            #1;
            start     = 1'b1;
            base_addr = 20'h12345;
            @(posedge clk);
            #1;
            start     = 1'b0;
        end
        budget = total * 10 + 50;
        while (done_cyc < 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        if (total == 0) begin
            chk("zero_done_cycle", 64'(done_cyc), 64'd2);
            chk("zero_no_read", 64'(saw_ren), 64'd0);
            chk("zero_no_valid", 64'(saw_vld), 64'd0);
        end else begin
            chk("done_after_last_beat", 64'(done_cyc), 64'(last_hs + 1));
            chk("first_valid_cycle", 64'(first_vld), 64'd3);
        end
        @(negedge clk);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("beats_left", 64'(exp_beat.size()), 64'd0);
        chk("reads_left", 64'(exp_addr.size()), 64'd0);
        exp_beat.delete();
        exp_addr.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int total;
        reset = 1'b1; start = 1'b0;
        Matrix_Row = '0; Matrix_Col = '0; base_addr = '0;
        mem_rdata = '0;
        first_vld = -1; done_cyc = -1; last_hs = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_ren", 64'(mem_ren), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_payload", m_payload, 64'd0);
        reset = 1'b0;

        mem_mode = 0;
        run_block(288, 32, 20'h0, 0, 0);
        run_block(288, 32, 20'h0, 1, 1);
        run_block(0, 32, 20'h0, 0, 0);
        run_block(1, 32, 20'hFFFFE, 0, 0);

        // Asynchronous reset while a beat is being presented.
        mem_mode = 2;
        rdy_mode = 2;
        push_exp(64, 64, 20'h00400, total);
        do_start(64, 64, 20'h00400);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i >= 10 && m_valid) break;
        end
        chk("mid_run_valid", 64'(m_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_payload", m_payload, 64'd0);
        chk("arst_last", 64'(m_last), 64'd0);
        chk("arst_ren", 64'(mem_ren), 64'd0);
        chk("arst_raddr", 64'(mem_raddr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        exp_beat.delete();
        exp_addr.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_block(4, 16, 20'h00400, 0, 0);

        for (int t = 0; t < 6; t++) begin
            run_block($urandom_range(0, 24), 8 * $urandom_range(0, 8) + $urandom_range(0, 7),
                      20'($urandom), $urandom_range(0, 2), 0);
        end

`ifdef WEIGHT_SRC_CHECKSUM_EN
        mem_mode = 1;
        run_block(8, 8, 20'h0, 0, 0);
        chk("checksum_all_ff", 64'(checksum), 64'(32'hFFFFFFC0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
